// File: rtl/scratchpad_mem_arbiter.sv
// Shares one word-wide memory port between row-wide scratchpad loads/stores,
// which are split into word beats, and single-word core accesses (round-robin).
//
// state | meaning
// IDLE  | no transfer in flight; arbitrate scratchpad vs core
// SP_LD | scratchpad row load, one word beat per memory access
// SP_ST | scratchpad row store, one word beat per memory access
// CORE  | single core word access
// DONE  | one-cycle row completion, sLoad_hit or sStore_hit asserted
module scratchpad_mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int BITS_PER_ROW = 64,
    parameter int ROW_S_W      = 2,
    parameter int NUM_ROWS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sLoad,
    input  logic                    sStore,
    input  logic [WORD_W-1:0]       load_addr,
    input  logic [WORD_W-1:0]       store_addr,
    input  logic [BITS_PER_ROW-1:0] store_data,
    output logic [BITS_PER_ROW-1:0] load_data,
    output logic                    sLoad_hit,
    output logic                    sStore_hit,
    output logic [ROW_S_W-1:0]      sLoad_row,
    input  logic                    core_ren,
    input  logic                    core_wen,
    input  logic [WORD_W-1:0]       core_addr,
    input  logic [WORD_W-1:0]       core_wdata,
    output logic [WORD_W-1:0]       core_rdata,
    output logic                    core_ready,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [WORD_W-1:0]       mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic [WORD_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);

    localparam int BEATS  = BITS_PER_ROW / WORD_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [WORD_W-1:0] STRIDE = WORD_W'(WORD_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        SP_LD,
        SP_ST,
        CORE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [BEAT_W-1:0]       beat;
    logic [ROW_S_W-1:0]      row_cnt;
    logic                    last_sp;
    logic                    sp_ld_q;
    logic [WORD_W-1:0]       base_addr;
    logic [BITS_PER_ROW-1:0] row_wdata;
    logic                    core_wr_q;
    logic [WORD_W-1:0]       core_addr_q;
    logic [WORD_W-1:0]       core_wdata_q;

    logic                    sp_req;
    logic                    core_req;
    logic                    grant_sp;
    logic                    grant_core;
    logic                    last_beat;
    logic                    row_last;
    logic [WORD_W-1:0]       beat_addr;
    logic [WORD_W-1:0]       beat_word;

    assign sp_req     = sLoad | sStore;
    assign core_req   = core_ren | core_wen;
    // last_sp low means the core had the previous grant, so the scratchpad wins a tie
    assign grant_sp   = sp_req & (~core_req | ~last_sp);
    assign grant_core = core_req & ~grant_sp;

    assign last_beat  = (beat == BEAT_W'(BEATS - 1));
    assign row_last   = (row_cnt == ROW_S_W'(NUM_ROWS - 1));
    assign beat_addr  = base_addr + (WORD_W'(beat) * STRIDE);

    assign core_rdata = mem_rdata;
    assign sLoad_row  = row_cnt;

    always_comb begin
        beat_word = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                beat_word = row_wdata[b*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sLoad_hit  = 1'b0;
        sStore_hit = 1'b0;
        core_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_sp) begin
                    state_nxt = sStore ? SP_ST : SP_LD;
                end else if (grant_core) begin
                    state_nxt = CORE;
                end
            end
            SP_LD: begin
                mem_ren  = 1'b1;
                mem_addr = beat_addr;
                if (mem_ready && last_beat) begin
                    state_nxt = DONE;
                end
            end
            SP_ST: begin
                mem_wen   = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = beat_word;
                if (mem_ready && last_beat) begin
                    state_nxt = DONE;
                end
            end
            CORE: begin
                mem_ren    = ~core_wr_q;
                mem_wen    = core_wr_q;
                mem_addr   = core_addr_q;
                mem_wdata  = core_wr_q ? core_wdata_q : '0;
                core_ready = mem_ready;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                sLoad_hit  = sp_ld_q;
                sStore_hit = ~sp_ld_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat         <= '0;
            row_cnt      <= '0;
            last_sp      <= 1'b0;
            sp_ld_q      <= 1'b0;
            base_addr    <= '0;
            row_wdata    <= '0;
            core_wr_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            load_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (grant_sp) begin
                        last_sp   <= 1'b1;
                        sp_ld_q   <= ~sStore;
                        base_addr <= sStore ? store_addr : load_addr;
                        row_wdata <= store_data;
                    end else if (grant_core) begin
                        last_sp      <= 1'b0;
                        core_wr_q    <= core_wen;
                        core_addr_q  <= core_addr;
                        core_wdata_q <= core_wdata;
                    end
                end
                SP_LD, SP_ST: begin
                    if (mem_ready) begin
                        if (state == SP_LD) begin
                            for (int b = 0; b < BEATS; b++) begin
                                if (beat == BEAT_W'(b)) begin
                                    load_data[b*WORD_W +: WORD_W] <= mem_rdata;
                                end
                            end
                        end
                        beat <= last_beat ? '0 : beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    if (sp_ld_q) begin
                        row_cnt <= row_last ? '0 : row_cnt + ROW_S_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scratchpad_mem_arbiter.sv
// Bench for scratchpad_mem_arbiter: latency-programmable memory model, a
// transaction-level round-robin model with scoreboards, and directed scenarios.
module tb_scratchpad_mem_arbiter;

    localparam int NUM_ROWS = 4;
    localparam int BEATS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sLoad = 1'b0, sStore = 1'b0;
    logic [31:0] load_addr = '0, store_addr = '0;
    logic [63:0] store_data = '0;
    logic [63:0] load_data;
    logic        sLoad_hit, sStore_hit;
    logic [1:0]  sLoad_row;
    logic        core_ren = 1'b0, core_wen = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    scratchpad_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .sLoad(sLoad), .sStore(sStore),
        .load_addr(load_addr), .store_addr(store_addr), .store_data(store_data),
        .load_data(load_data), .sLoad_hit(sLoad_hit), .sStore_hit(sStore_hit),
        .sLoad_row(sLoad_row),
        .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // memory: answers k cycles after it first samples a strobe
    logic [31:0] mem_arr [logic [31:0]];
    int mem_k   = 1;
    int mem_cnt = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_ren || mem_wen) begin
            if (mem_cnt == mem_k - 1) begin
                mem_ready <= 1'b1;
                mem_cnt   <= 0;
                if (mem_wen) mem_arr[mem_addr] = mem_wdata;
                else         mem_rdata <= rd_word(mem_addr);
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    typedef struct { logic wr; logic core; logic [31:0] addr; logic [31:0] data; } acc_t;
    typedef struct { logic ld; logic [63:0] data; logic [1:0] row; } hit_t;
    typedef struct { logic st; logic [31:0] addr; logic [63:0] data; } sp_req_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } core_req_t;

    acc_t      exp_acc[$];
    hit_t      exp_hit[$];
    sp_req_t   sp_list[$];
    core_req_t core_list[$];
    logic      seen[$];
    logic      seen_exp[$];
    int        rows_seen[$];
    logic      m_last_sp = 1'b0;
    int        m_row = 0;
    int        sp_lat = -1;
    logic [63:0] last_ld = '0;

    task automatic push_load(input logic [31:0] a);
        logic [63:0] d;
        logic [31:0] w;
        for (int i = 0; i < BEATS; i++) begin
            w = rd_word(a + 32'(i * 4));
            d[i*32 +: 32] = w;
            exp_acc.push_back('{1'b0, 1'b0, a + 32'(i * 4), w});
        end
        exp_hit.push_back('{1'b1, d, 2'(m_row)});
        m_row = (m_row + 1) % NUM_ROWS;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [63:0] d);
        for (int i = 0; i < BEATS; i++)
            exp_acc.push_back('{1'b1, 1'b0, a + 32'(i * 4), d[i*32 +: 32]});
        exp_hit.push_back('{1'b0, 64'h0, 2'h0});
    endtask

    task automatic push_core(input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_acc.push_back('{wr, 1'b1, a, wr ? d : rd_word(a)});
    endtask

    acc_t ca;
    hit_t ch;
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_exclusive", {63'h0, mem_ren & mem_wen}, 64'h0);
            if (mem_ready) begin
                if (exp_acc.size() == 0) begin
                    fail("unexpected_access", mem_addr);
                end else begin
                    ca = exp_acc.pop_front();
                    chk("acc_wen", mem_wen, ca.wr);
                    chk("acc_ren", mem_ren, !ca.wr);
                    chk("acc_addr", mem_addr, ca.addr);
                    if (ca.wr) chk("acc_wdata", mem_wdata, ca.data);
                    chk("acc_core_ready", core_ready, ca.core);
                    if (ca.core && !ca.wr) chk("core_rdata", core_rdata, ca.data);
                    if (ca.core) seen.push_back(1'b0);
                end
            end
            if (sLoad_hit || sStore_hit) begin
                if (exp_hit.size() == 0) begin
                    fail("unexpected_hit", {sLoad_hit, sStore_hit});
                end else begin
                    ch = exp_hit.pop_front();
                    chk("hit_kind", {sLoad_hit, sStore_hit}, ch.ld ? 2'b10 : 2'b01);
                    if (ch.ld) begin
                        chk("load_data", load_data, ch.data);
                        chk("sLoad_row", sLoad_row, ch.row);
                    end
                    seen.push_back(1'b1);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sLoad = 1'b0; sStore = 1'b0; core_ren = 1'b0; core_wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_acc.delete(); exp_hit.delete(); seen.delete(); seen_exp.delete();
        sp_list.delete(); core_list.delete(); rows_seen.delete();
        m_last_sp = 1'b0;
        m_row     = 0;
        rst = 1'b0;
    endtask

    task automatic sp_apply(input sp_req_t r);
        sStore = r.st;
        sLoad  = !r.st;
        if (r.st) begin
            store_addr = r.addr;
            store_data = r.data;
        end else begin
            load_addr = r.addr;
        end
    endtask

    task automatic sp_drive();
        int n;
        logic hit;
        for (int k = 0; k < sp_list.size(); k++) begin
            if (k == 0) sp_apply(sp_list[0]);
            n = 0;
            do begin
                @(posedge clk); #1; n++;
                hit = sp_list[k].st ? sStore_hit : sLoad_hit;
            end while (!hit && n < 400);
            chk("sp_completion", hit, 1'b1);
            if (!hit) begin
                sLoad = 1'b0; sStore = 1'b0;
                return;
            end
            if (k == 0) sp_lat = n - 1;
            if (!sp_list[k].st) begin
                rows_seen.push_back(int'(sLoad_row));
                last_ld = load_data;
            end
            if (k + 1 < sp_list.size()) sp_apply(sp_list[k+1]);
            else begin sLoad = 1'b0; sStore = 1'b0; end
        end
    endtask

    task automatic core_drive();
        int n;
        for (int k = 0; k < core_list.size(); k++) begin
            core_wen = core_list[k].wr; core_ren = !core_list[k].wr;
            core_addr = core_list[k].addr; core_wdata = core_list[k].data;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!core_ready && n < 400);
            chk("core_completion", core_ready, 1'b1);
            if (!core_ready) break;
        end
        core_ren = 1'b0; core_wen = 1'b0;
    endtask

    // round-robin over the two request lists, each side presenting continuously
    task automatic run_scenario();
        int i = 0;
        int j = 0;
        seen.delete(); seen_exp.delete(); rows_seen.delete();
        while (i < sp_list.size() || j < core_list.size()) begin
            if (i < sp_list.size() && (j >= core_list.size() || !m_last_sp)) begin
                if (sp_list[i].st) push_store(sp_list[i].addr, sp_list[i].data);
                else               push_load(sp_list[i].addr);
                m_last_sp = 1'b1; seen_exp.push_back(1'b1); i++;
            end else begin
                push_core(core_list[j].wr, core_list[j].addr, core_list[j].data);
                m_last_sp = 1'b0; seen_exp.push_back(1'b0); j++;
            end
        end
        fork
            sp_drive();
            core_drive();
        join
        @(negedge clk); #1;
        chk("acc_drained", 64'(exp_acc.size()), 64'h0);
        chk("hit_drained", 64'(exp_hit.size()), 64'h0);
        chk("order_count", 64'(seen.size()), 64'(seen_exp.size()));
        for (int q = 0; q < seen.size() && q < seen_exp.size(); q++)
            chk("grant_order", seen[q], seen_exp[q]);
    endtask

    task automatic wait_any_hit();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!(sLoad_hit || sStore_hit) && n < 400);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rows [5] = '{0, 1, 2, 3, 0};
        int n;

        do_reset();
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hits", {sLoad_hit, sStore_hit}, 2'b00);
        chk("rst_row", sLoad_row, 2'h0);
        chk("rst_load_data", load_data, 64'h0);
        chk("rst_core_ready", core_ready, 1'b0);

        // lone load, k=1
        mem_arr[32'h100] = 32'hAAAA_0001;
        mem_arr[32'h104] = 32'hBBBB_0002;
        mem_k = 1;
        sp_list.push_back('{1'b0, 32'h100, 64'h0});
        run_scenario();
        chk("t1_latency", sp_lat, 4);
        chk("t1_load_data", last_ld, 64'hBBBB0002_AAAA0001);
        chk("t1_row", rows_seen.size() > 0 ? rows_seen[0] : -1, 0);

        // lone store
        do_reset();
        sp_list.push_back('{1'b1, 32'h200, 64'h11223344_55667788});
        run_scenario();
        @(posedge clk); #1;
        chk("t2_hit_one_cycle", sStore_hit, 1'b0);
        chk("t2_word0", rd_word(32'h200), 32'h55667788);
        chk("t2_word1", rd_word(32'h204), 32'h11223344);

        // ties from reset: scratchpad, core, scratchpad, core
        do_reset();
        sp_list.push_back('{1'b0, 32'h300, 64'h0});
        sp_list.push_back('{1'b0, 32'h308, 64'h0});
        core_list.push_back('{1'b0, 32'h400, 32'h0});
        core_list.push_back('{1'b0, 32'h404, 32'h0});
        run_scenario();
        chk("t3_model_order", {seen_exp[0], seen_exp[1], seen_exp[2], seen_exp[3]}, 4'b1010);
        chk("t3_dut_order", seen.size() == 4 ? {seen[0], seen[1], seen[2], seen[3]} : 4'hF, 4'b1010);

        // store beats load inside the scratchpad
        do_reset();
        push_store(32'h500, 64'hDEADBEEF_0BADF00D);
        push_load(32'h600);
        sStore = 1'b1; store_addr = 32'h500; store_data = 64'hDEADBEEF_0BADF00D;
        sLoad = 1'b1;  load_addr = 32'h600;
        wait_any_hit();
        chk("t4_first_store", {sStore_hit, sLoad_hit}, 2'b10);
        sStore = 1'b0;
        wait_any_hit();
        chk("t4_then_load", {sStore_hit, sLoad_hit}, 2'b01);
        sLoad = 1'b0;
        @(negedge clk); #1;
        chk("t4_acc_drained", 64'(exp_acc.size()), 64'h0);
        chk("t4_hit_drained", 64'(exp_hit.size()), 64'h0);

        // five back-to-back loads, k=2
        do_reset();
        mem_k = 2;
        for (int r = 0; r < 5; r++) sp_list.push_back('{1'b0, 32'h1000 + 32'(r * 16), 64'h0});
        run_scenario();
        chk("t5_latency", sp_lat, 2 + BEATS * 2);
        for (int r = 0; r < 5; r++)
            chk("t5_row", r < rows_seen.size() ? rows_seen[r] : -1, exp_rows[r]);

        // reset during beat 1 of a load
        do_reset();
        mem_k = 1;
        push_load(32'h700);
        sLoad = 1'b1; load_addr = 32'h700;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(mem_ren && mem_addr == 32'h704) && n < 50);
        chk("t6_reached_beat1", mem_addr, 32'h704);
        rst = 1'b1; sLoad = 1'b0;
        @(posedge clk); #1;
        chk("t6_strobes_low", {mem_ren, mem_wen}, 2'b00);
        chk("t6_no_hit", sLoad_hit, 1'b0);
        chk("t6_row", sLoad_row, 2'h0);
        exp_acc.delete(); exp_hit.delete();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_row_after", sLoad_row, 2'h0);

        // core write beats core read
        do_reset();
        push_core(1'b1, 32'h800, 32'hCAFEF00D);
        core_wen = 1'b1; core_ren = 1'b1; core_addr = 32'h800; core_wdata = 32'hCAFEF00D;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!core_ready && n < 50);
        chk("t7_core_ready", core_ready, 1'b1);
        core_wen = 1'b0; core_ren = 1'b0;
        @(negedge clk); #1;
        chk("t7_mem_written", rd_word(32'h800), 32'hCAFEF00D);
        chk("t7_acc_drained", 64'(exp_acc.size()), 64'h0);

        // address wrap across 2^32, k=3
        do_reset();
        mem_k = 3;
        sp_list.push_back('{1'b0, 32'hFFFF_FFFC, 64'h0});
        run_scenario();
        chk("t8_latency", sp_lat, 8);
        chk("t8_load_data", last_ld, 64'h5A5A0000_A5A6FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
